// File: rtl/decode_stage_if.sv
// Fetch->decode->execute bundle plus register-file writeback port for decode_stage.
// master = the surrounding pipeline (fetch/writeback/execute side), slave = decode_stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic [31:0]     if_ir;
  logic            if_valid;
  logic            stall;
  logic            flush;
  // writeback side
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  // decoded bundle to execute
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [6:0]      id_funct7;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_illegal;

  modport master (
    output if_ir, if_valid, stall, flush, wb_we, wb_rd, wb_data,
    input  id_valid, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7,
           id_rs1_data, id_rs2_data, id_imm, id_illegal
  );

  modport slave (
    input  if_ir, if_valid, stall, flush, wb_we, wb_rd, wb_data,
    output id_valid, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7,
           id_rs1_data, id_rs2_data, id_imm, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers the instruction fields, immediate and 32x32 register-file reads.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback into the captured read data.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32
) (
  input logic           clk1,
  input logic           rst,
  decode_stage_if.slave dif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Field split of the incoming word
  // ---------------------------------------------------------------------------
  logic [31:0] ir;
  logic [6:0]  opcode_w;
  logic [4:0]  rd_w;
  logic [2:0]  funct3_w;
  logic [4:0]  rs1_w;
  logic [4:0]  rs2_w;
  logic [6:0]  funct7_w;

  assign ir       = dif.if_ir;
  assign opcode_w = ir[6:0];
  assign rd_w     = ir[11:7];
  assign funct3_w = ir[14:12];
  assign rs1_w    = ir[19:15];
  assign rs2_w    = ir[24:20];
  assign funct7_w = ir[31:25];

  // ---------------------------------------------------------------------------
  // Immediate generation and legality. The full 7-bit opcode compare also
  // rejects any word whose low two bits are not 2'b11.
  // ---------------------------------------------------------------------------
  logic [31:0] imm_w;
  logic        illegal_w;

  always_comb begin
    imm_w     = '0;
    illegal_w = 1'b0;
    case (opcode_w)
      OP_IMM, OP_LOAD, OP_JALR:
        imm_w = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:
        imm_w = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:
        imm_w = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_w = {ir[31:12], 12'b0};
      OP_JAL:
        imm_w = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_REG, OP_FENCE, OP_SYSTEM:
        imm_w = '0;
      default:
        illegal_w = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: reset-clearable, combinational read, x0 never written.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [RF_DEPTH];
  logic            wb_hit_w;

  assign wb_hit_w = dif.wb_we && (dif.wb_rd != 5'd0);

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_hit_w) begin
      rf_q[dif.wb_rd] <= dif.wb_data;
    end
  end

  logic [XLEN-1:0] rf_rs1_w;
  logic [XLEN-1:0] rf_rs2_w;
  logic [XLEN-1:0] rs1_data_w;
  logic [XLEN-1:0] rs2_data_w;

  assign rf_rs1_w = (rs1_w == 5'd0) ? '0 : rf_q[rs1_w];
  assign rf_rs2_w = (rs2_w == 5'd0) ? '0 : rf_q[rs2_w];

`ifdef REGFILE_BYPASS_EN
  // Each read port forwards independently; wb_hit_w already excludes x0.
  assign rs1_data_w = (wb_hit_w && (dif.wb_rd == rs1_w)) ? dif.wb_data : rf_rs1_w;
  assign rs2_data_w = (wb_hit_w && (dif.wb_rd == rs2_w)) ? dif.wb_data : rf_rs2_w;
`else
  // No forwarding: writeback must lead decode by a cycle (hazard unit's job).
  assign rs1_data_w = rf_rs1_w;
  assign rs2_data_w = rf_rs2_w;
`endif

  // ---------------------------------------------------------------------------
  // Output bundle registers. Priority: rst > flush > stall > capture.
  // ---------------------------------------------------------------------------
  logic            valid_q,    valid_d;
  logic [6:0]      opcode_q,   opcode_d;
  logic [4:0]      rd_q,       rd_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [6:0]      funct7_q,   funct7_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic            illegal_q,  illegal_d;

  always_comb begin
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    funct7_d   = funct7_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    illegal_d  = illegal_q;
    if (dif.flush) begin
      valid_d    = 1'b0;
      opcode_d   = '0;
      rd_d       = '0;
      funct3_d   = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      funct7_d   = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      illegal_d  = 1'b0;
    end else if (!dif.stall) begin
      valid_d    = dif.if_valid;
      opcode_d   = opcode_w;
      rd_d       = rd_w;
      funct3_d   = funct3_w;
      rs1_d      = rs1_w;
      rs2_d      = rs2_w;
      funct7_d   = funct7_w;
      rs1_data_d = rs1_data_w;
      rs2_data_d = rs2_data_w;
      imm_d      = imm_w;
      illegal_d  = illegal_w;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct7_q   <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      funct7_q   <= funct7_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      illegal_q  <= illegal_d;
    end
  end

  assign dif.id_valid    = valid_q;
  assign dif.id_opcode   = opcode_q;
  assign dif.id_rd       = rd_q;
  assign dif.id_funct3   = funct3_q;
  assign dif.id_rs1      = rs1_q;
  assign dif.id_rs2      = rs2_q;
  assign dif.id_funct7   = funct7_q;
  assign dif.id_rs1_data = rs1_data_q;
  assign dif.id_rs2_data = rs2_data_q;
  assign dif.id_imm      = imm_q;
  assign dif.id_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-computed encodings.
module tb_decode_stage;

  logic clk1 = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  decode_stage_if #(.XLEN(32)) dif ();

  decode_stage u_dut (
    .clk1 (clk1),
    .rst  (rst),
    .dif  (dif)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end else begin
      $display("ok   %s act=%h", tag, act);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    dif.if_ir    = 32'h0;
    dif.if_valid = 1'b0;
    dif.stall    = 1'b0;
    dif.flush    = 1'b0;
    dif.wb_we    = 1'b0;
    dif.wb_rd    = 5'd0;
    dif.wb_data  = 32'h0;
  endtask

  logic [31:0] exp_bypass;

  initial begin
    idle_inputs();
    // Reset must override a capture and a writeback presented at the same time.
    rst          = 1'b1;
    dif.if_ir    = 32'hFFF2_8093;
    dif.if_valid = 1'b1;
    dif.wb_we    = 1'b1;
    dif.wb_rd    = 5'd5;
    dif.wb_data  = 32'hCAFE_0001;
    @(negedge clk1);
    tick();
    rst = 1'b0;
    idle_inputs();
    check("rst_valid",   {31'b0, dif.id_valid}, 32'h0);
    check("rst_imm",     dif.id_imm, 32'h0);
    check("rst_opcode",  {25'b0, dif.id_opcode}, 32'h0);
    check("rst_rs1",     {27'b0, dif.id_rs1}, 32'h0);
    check("rst_rs1data", dif.id_rs1_data, 32'h0);
    check("rst_illegal", {31'b0, dif.id_illegal}, 32'h0);

    // Every register reads zero after reset (x5 write during reset discarded).
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      dif.if_ir    = {7'b0, r, r, 3'b000, 5'd0, 7'b0110011};
      dif.if_valid = 1'b1;
      tick();
      check($sformatf("rf_rs1_x%0d", i), {27'b0, dif.id_rs1}, {27'b0, r});
      check($sformatf("rf_rd1_x%0d", i), dif.id_rs1_data, 32'h0);
      check($sformatf("rf_rd2_x%0d", i), dif.id_rs2_data, 32'h0);
    end
    idle_inputs();

    // addi x1,x5,-1 after writing x5.
    dif.wb_we = 1'b1; dif.wb_rd = 5'd5; dif.wb_data = 32'h1234_5678;
    tick();
    idle_inputs();
    dif.if_ir = 32'hFFF2_8093; dif.if_valid = 1'b1;
    tick();
    check("addi_valid",   {31'b0, dif.id_valid}, 32'h1);
    check("addi_imm",     dif.id_imm, 32'hFFFF_FFFF);
    check("addi_rs1",     {27'b0, dif.id_rs1}, 32'd5);
    check("addi_rd",      {27'b0, dif.id_rd}, 32'd1);
    check("addi_opcode",  {25'b0, dif.id_opcode}, 32'h13);
    check("addi_rs1data", dif.id_rs1_data, 32'h1234_5678);
    check("addi_illegal", {31'b0, dif.id_illegal}, 32'h0);

    // Stall holds the bundle and drops the new word.
    dif.stall = 1'b1; dif.if_ir = 32'h1234_50B7; dif.if_valid = 1'b1;
    tick();
    check("stall_imm",    dif.id_imm, 32'hFFFF_FFFF);
    check("stall_opcode", {25'b0, dif.id_opcode}, 32'h13);
    check("stall_valid",  {31'b0, dif.id_valid}, 32'h1);
    // Flush wins over stall.
    dif.flush = 1'b1;
    tick();
    check("flush_valid",   {31'b0, dif.id_valid}, 32'h0);
    check("flush_imm",     dif.id_imm, 32'h0);
    check("flush_rs1data", dif.id_rs1_data, 32'h0);
    idle_inputs();

    // Immediate formats and legality.
    dif.if_valid = 1'b1;
    dif.if_ir = 32'hFE00_0EE3; tick();
    check("beq_imm", dif.id_imm, 32'hFFFF_FFFC);
    check("beq_ill", {31'b0, dif.id_illegal}, 32'h0);
    dif.if_ir = 32'hFE50_2E23; tick();
    check("sw_imm",  dif.id_imm, 32'hFFFF_FFFC);
    check("sw_rs2data", dif.id_rs2_data, 32'h1234_5678);
    dif.if_ir = 32'h1234_50B7; tick();
    check("lui_imm", dif.id_imm, 32'h1234_5000);
    dif.if_ir = 32'h8000_00EF; tick();
    check("jal_imm", dif.id_imm, 32'hFFF0_0000);
    dif.if_ir = 32'h0000_0033; tick();
    check("add_imm", dif.id_imm, 32'h0);
    check("add_ill", {31'b0, dif.id_illegal}, 32'h0);
    dif.if_ir = 32'h0000_0000; tick();
    check("zero_ill",   {31'b0, dif.id_illegal}, 32'h1);
    check("zero_imm",   dif.id_imm, 32'h0);
    check("zero_valid", {31'b0, dif.id_valid}, 32'h1);
    dif.if_ir = 32'hFFF2_8092; dif.if_valid = 1'b0; tick();
    check("lowbits_ill",   {31'b0, dif.id_illegal}, 32'h1);
    check("lowbits_imm",   dif.id_imm, 32'h0);
    check("lowbits_valid", {31'b0, dif.id_valid}, 32'h0);
    check("lowbits_rs1",   {27'b0, dif.id_rs1}, 32'd5);
    idle_inputs();

    // Write to x0 is discarded.
    dif.wb_we = 1'b1; dif.wb_rd = 5'd0; dif.wb_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    dif.if_ir = 32'h0000_0093; dif.if_valid = 1'b1;
    tick();
    check("x0_rs1data", dif.id_rs1_data, 32'h0);

    // Same-cycle writeback of x7 with a capture reading rs2=x7 (add x1,x0,x7).
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 32'hA5A5_A5A5;
`else
    exp_bypass = 32'h0;
`endif
    dif.if_ir = 32'h0070_00B3; dif.if_valid = 1'b1;
    dif.wb_we = 1'b1; dif.wb_rd = 5'd7; dif.wb_data = 32'hA5A5_A5A5;
    tick();
    check("wbsame_rs2data", dif.id_rs2_data, exp_bypass);
    check("wbsame_rs1data", dif.id_rs1_data, 32'h0);
    dif.wb_we = 1'b0;
    tick();
    check("wbnext_rs2data", dif.id_rs2_data, 32'hA5A5_A5A5);

    // Flush does not block a writeback.
    idle_inputs();
    dif.flush = 1'b1; dif.wb_we = 1'b1; dif.wb_rd = 5'd9; dif.wb_data = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    dif.if_ir = 32'h0004_8093; dif.if_valid = 1'b1;
    tick();
    check("flushwb_rs1data", dif.id_rs1_data, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
